// File: rtl/wb_mem_resp.sv
// Pipelined Wishbone B4 slave memory with a fixed ack latency and an outstanding-request limit.
// Optional macro WB_MEM_RANDOM_STALL_EN adds LFSR-driven pseudo-random stalls.
module wb_mem_resp #(
    parameter int G_ADDR_BITS       = 8,
    parameter int G_LATENCY         = 2,
    parameter int G_MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_stall_o,
    input  logic [15:0] wb_addr_i,
    input  logic        wb_we_i,
    input  logic [15:0] wb_dat_i,
    output logic        wb_ack_o,
    output logic [15:0] wb_data_o
);

    localparam int DEPTH = 2 ** G_ADDR_BITS;
    localparam int CNT_W = $clog2(G_MAX_OUTSTANDING + 1);

    typedef logic [15:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = 16'(i);
        end
        return m;
    endfunction

    mem_t mem = mem_init();

    logic [G_LATENCY-1:0]   vld_p;
    logic [15:0]            dat_p [G_LATENCY];
    logic [CNT_W-1:0]       cnt_q;
    logic [15:0]            hold_q;
    logic [G_ADDR_BITS-1:0] addr_idx;
    logic                   accept;
    logic                   limit_stall;
    logic                   unused_addr;

    assign addr_idx    = wb_addr_i[G_ADDR_BITS-1:0];
    assign unused_addr = ^wb_addr_i;
    assign limit_stall = (cnt_q == CNT_W'(G_MAX_OUTSTANDING));
    assign accept      = wb_cyc_i & wb_stb_i & ~wb_stall_o;
    assign wb_ack_o    = vld_p[G_LATENCY-1] & wb_cyc_i;
    assign wb_data_o   = wb_ack_o ? dat_p[G_LATENCY-1] : hold_q;

`ifdef WB_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign wb_stall_o = limit_stall | (lfsr[1:0] == 2'b00);
`else
    assign wb_stall_o = limit_stall;
`endif

    // Control: valid pipeline, outstanding count, held output data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p  <= '0;
            cnt_q  <= '0;
            hold_q <= 16'h0000;
        end else begin
            if (wb_ack_o) begin
                hold_q <= dat_p[G_LATENCY-1];
            end
            if (!wb_cyc_i) begin
                vld_p <= '0;
                cnt_q <= '0;
            end else begin
                vld_p[0] <= accept;
                for (int i = 1; i < G_LATENCY; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
                case ({accept, wb_ack_o})
                    2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                    2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // Data: single-port memory and response data pipeline, never reset
    always_ff @(posedge clk_i) begin
        if (accept && wb_we_i) begin
            mem[addr_idx] <= wb_dat_i;
        end
        dat_p[0] <= wb_we_i ? 16'h0000 : mem[addr_idx];
        for (int i = 1; i < G_LATENCY; i++) begin
            dat_p[i] <= dat_p[i-1];
        end
    end

endmodule

// File: tb/tb_wb_mem_resp.sv
// Scoreboard bench for wb_mem_resp: requests push expected {data, due cycle}, acks pop and compare.
module tb_wb_mem_resp;

    localparam int ADDR_BITS = 8;
    localparam int LAT       = 2;
    localparam int MAX_OUT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [15:0] dat  = 16'h0;
    logic        stall;
    logic        ack;
    logic [15:0] rdata;

    wb_mem_resp #(
        .G_ADDR_BITS(ADDR_BITS),
        .G_LATENCY(LAT),
        .G_MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .wb_cyc_i(cyc),
        .wb_stb_i(stb),
        .wb_stall_o(stall),
        .wb_addr_i(addr),
        .wb_we_i(we),
        .wb_dat_i(dat),
        .wb_ack_o(ack),
        .wb_data_o(rdata)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [15:0] d;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_mem [2**ADDR_BITS];
    logic        r_we   [8];
    logic [15:0] r_addr [8];
    logic [15:0] r_dat  [8];
    logic [15:0] last_data;
    logic        have_last = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // Drives n requests from r_* honouring stall; checks every ack against the scoreboard.
    task automatic run_traffic(input int n, input string name, output int stall_cyc);
        int   idx;
        int   tail;
        int   budget;
        exp_t e;
        idx = 0; tail = 0; budget = 0; stall_cyc = 0;
        cyc = 1'b1;
        while (tail < 3 && budget < 60) begin
            @(negedge clk);
            budget++;
            if (ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_ack data=%h at cycle %0d", name, rdata, cyc_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.d || cyc_cnt != e.due) begin
                        failures++;
                        $display("FAIL %s ack got data=%h cycle=%0d want data=%h cycle=%0d",
                                 name, rdata, cyc_cnt, e.d, e.due);
                    end
                end
                last_data = rdata;
                have_last = 1'b1;
            end else begin
                if (exp_q.size() != 0 && exp_q[0].due <= cyc_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL %s missing_ack want data=%h due=%0d now=%0d",
                             name, exp_q[0].d, exp_q[0].due, cyc_cnt);
                    void'(exp_q.pop_front());
                end
                if (have_last) begin
                    checks++;
                    if (rdata !== last_data) begin
                        failures++;
                        $display("FAIL %s data_hold got=%h want=%h", name, rdata, last_data);
                    end
                end
            end
            if (idx < n) begin
                stb  = 1'b1;
                we   = r_we[idx];
                addr = r_addr[idx];
                dat  = r_dat[idx];
                if (stall) begin
                    stall_cyc++;
                end else begin
                    e.due = cyc_cnt + LAT;
                    if (r_we[idx]) begin
                        e.d = 16'h0000;
                        model_mem[r_addr[idx][ADDR_BITS-1:0]] = r_dat[idx];
                    end else begin
                        e.d = model_mem[r_addr[idx][ADDR_BITS-1:0]];
                    end
                    exp_q.push_back(e);
                    idx++;
                end
            end else begin
                stb = 1'b0;
                we  = 1'b0;
                if (exp_q.size() == 0) tail++;
            end
        end
        if (budget >= 60) begin
            checks++;
            failures++;
            $display("FAIL %s timeout pending=%0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b want=0", ack); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall); end
        checks++;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h want=0000", rdata); end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int sc;
        r_we[0] = 1'b0; r_addr[0] = 16'h0005; r_dat[0] = 16'h0;
        run_traffic(1, "single_read", sc);
        checks++;
        if (sc != 0) begin failures++; $display("FAIL single_read_stall got=%0d want=0", sc); end
    endtask

    task automatic test_back_to_back();
        int sc;
        for (int i = 0; i < 3; i++) begin
            r_we[i] = 1'b0; r_addr[i] = 16'h0010 + 16'(i); r_dat[i] = 16'h0;
        end
        run_traffic(3, "back_to_back", sc);
        checks++;
        if (sc != 1) begin failures++; $display("FAIL back_to_back_stall_cycles got=%0d want=1", sc); end
    endtask

    task automatic test_write_read();
        int sc;
        r_we[0] = 1'b1; r_addr[0] = 16'h0020; r_dat[0] = 16'hBEEF;
        r_we[1] = 1'b0; r_addr[1] = 16'h0020; r_dat[1] = 16'h0;
        run_traffic(2, "write_read", sc);
    endtask

    task automatic test_alias();
        int sc;
        r_we[0] = 1'b1; r_addr[0] = 16'h0103; r_dat[0] = 16'h1234;
        r_we[1] = 1'b0; r_addr[1] = 16'h0003; r_dat[1] = 16'h0;
        run_traffic(2, "alias", sc);
    endtask

    task automatic test_abort();
        int sc;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 16'h0007;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b1; addr = 16'h0009;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin failures++; $display("FAIL abort_ack_cyc_low got=%b want=0", ack); end
        end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL abort_stall got=%b want=0", stall); end
        cyc = 1'b1; stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin failures++; $display("FAIL abort_stale_ack got=%b want=0", ack); end
        end
        for (int i = 0; i < 2; i++) begin
            r_we[i] = 1'b0; r_addr[i] = 16'h0008 + 16'(i); r_dat[i] = 16'h0;
        end
        run_traffic(2, "after_abort", sc);
        checks++;
        if (sc != 0) begin failures++; $display("FAIL after_abort_stall got=%0d want=0", sc); end
    endtask

    task automatic test_async_reset();
        int sc;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 16'h0030;
        @(negedge clk);
        addr = 16'h0031;
        @(posedge clk);
        #2;
        stb = 1'b0;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL areset_pre_stall got=%b want=1", stall); end
        rst = 1'b1;
        #1;
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL areset_ack got=%b want=0", ack); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL areset_stall got=%b want=0", stall); end
        checks++;
        if (rdata !== 16'h0000) begin failures++; $display("FAIL areset_data got=%h want=0000", rdata); end
        @(negedge clk);
        rst = 1'b0;
        have_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ack !== 1'b0) begin failures++; $display("FAIL areset_stale_ack got=%b want=0", ack); end
        end
        r_we[0] = 1'b0; r_addr[0] = 16'h0020; r_dat[0] = 16'h0;
        r_we[1] = 1'b0; r_addr[1] = 16'h0040; r_dat[1] = 16'h0;
        r_we[2] = 1'b0; r_addr[2] = 16'h0003; r_dat[2] = 16'h0;
        run_traffic(3, "after_reset", sc);
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_BITS; i++) model_mem[i] = 16'(i);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write_read();
        test_alias();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
